mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - MEM-stage data-memory access controller, directly upstream of sram_control.
// - Turns pipeline load/store requests into sram_control read/write requests and
//   stalls the pipeline until the access completes.
// - Does byte-lane steering and byte enables for SB/SH/SW, and lane extraction with
//   sign/zero extension for LB/LBU/LH/LHU/LW. Little-endian.
// PARAMETERS
// - ADDR_W        32  pipeline/SRAM byte-address width
// - DATA_W        32  data width (fixed at 4 byte lanes)
// - WRITE_CYCLES   2  cycles sram_we_n is held low per store, legal range >=1
// PORTS
// - clk            in   1       clock
// - rst            in   1       asynchronous reset, active-high
// - req_valid      in   1       MEM-stage access request, held stable while stall_o=1
// - req_we         in   1       1=store, 0=load
// - req_size       in   2       00 byte, 01 half, 10 word, 11 treated as word
// - req_sign       in   1       loads: 1=sign-extend, 0=zero-extend
// - req_addr       in   ADDR_W  byte address
// - req_wdata      in   DATA_W  store data, right-aligned
// - stall_o        out  1       freeze pipeline (combinational)
// - resp_valid     out  1       one-cycle completion pulse
// - resp_rdata     out  DATA_W  extended load result, valid with resp_valid
// - resp_misalign  out  1       misaligned access flag (see CONFIGURATION)
// - sram_read_ena  out  1       read request to sram_control, 1-cycle pulse
// - sram_we_n      out  1       write strobe, active-low
// - sram_addr      out  ADDR_W  word address {req_addr[ADDR_W-1:2],2'b00}
// - sram_wdata     out  DATA_W  lane-replicated store data
// - sram_be_n      out  4       byte enables, active-low
// - sram_rvalid    in   1       read data valid from sram_control; may stay high after data
// - sram_rdata     in   DATA_W  read word from sram_control
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, sram_read_ena=0, sram_we_n=1, sram_be_n=4'hF,
//   sram_addr/sram_wdata=0, resp_valid=0, resp_rdata=0, resp_misalign=0, armed=0.
//   In-flight access is abandoned. No response is produced for it.
// - States: IDLE, RD_ISSUE, RD_WAIT, WR, DONE. All sram_* outputs and resp_* are registered.
// - IDLE: on req_valid, latch addr/size/sign/wdata/we.
//   - Load: go to RD_ISSUE. Store: go to WR, WR counter := WRITE_CYCLES-1.
// - RD_ISSUE: sram_read_ena=1 for exactly this cycle, armed:=0, then go to RD_WAIT.
// - RD_WAIT:
//   - armed:=1 on any cycle with sram_rvalid=0.
//   - Capture sram_rdata on the first cycle with armed=1 and sram_rvalid=1, then go to DONE.
//     This skips a stale valid left over from the previous read.
// - WR: sram_we_n=0, sram_addr/sram_wdata/sram_be_n held.
//   - Count down; when the counter reaches 0, go to DONE. we_n returns to 1 in DONE.
// - DONE: resp_valid=1 for one cycle, then go to IDLE. A new request is accepted only in IDLE.
// - stall_o = (state==IDLE & req_valid) | state in {RD_ISSUE, RD_WAIT, WR}. It is 0 in DONE.
// - Store steering (off=addr[1:0]):
//   - SB: wdata={4{b}}, be_n=~(4'b0001<<off).
//   - SH: wdata={2{h}}, be_n = addr[1] ? 4'b0011 : 4'b1100.
//   - SW: be_n=4'b0000.
// - Load extraction:
//   - LB: byte lane off. LH: half lane addr[1]. LW: full word.
//   - Extend to DATA_W from the MSB when req_sign=1; zero-fill otherwise.
// - sram_be_n=4'hF whenever no store is in progress.
// - Read latency: IDLE accept at cycle 0, read_ena at cycle 1, resp_valid at cycle 1+L+1,
//   where L = cycles from read_ena until first fresh sram_rvalid (L=2 with the current sram_control).
// - Store latency: resp_valid at cycle WRITE_CYCLES+1.
// CONFIGURATION
// - MEM_ALIGN_CHECK_EN defined:
//   - Misaligned half (addr[0]=1) or word (addr[1:0]!=0) issues no SRAM access.
//   - IDLE goes directly to DONE with resp_valid=1, resp_misalign=1, resp_rdata=0.
// - Not defined: resp_misalign tied 0.
//   - Half uses addr[1] only; word ignores addr[1:0]. The access proceeds normally.
// TESTING
// - LW 0x80000004, sram returns 0xDEADBEEF:
//   -> read_ena pulse at cycle 1, resp_valid at cycle 4, rdata 0xDEADBEEF, stall high cycles 0-3.
// - LB addr off=3, word 0x80112233: sign -> 0xFFFFFF80; LBU -> 0x00000080; LH addr[1]=1 -> 0xFFFF8011.
// - SB 0x5A off=1 -> sram_wdata 0x5A5A5A5A, be_n 4'b1101, we_n low 2 cycles,
//   resp_valid at cycle 3.
// - SH 0xBEEF addr[1]=1 -> be_n 4'b0011.
// - Back-to-back LW with sram_rvalid left high from the previous read
//   -> stale valid ignored; capture only after rvalid drops and rises.
// - rst asserted in RD_WAIT -> outputs at reset values immediately, no resp_valid.
//   Next LW completes normally.
// - MEM_ALIGN_CHECK_EN, LW addr 0x...2 -> no read_ena, resp_valid+resp_misalign at cycle 1,
//   rdata 0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bundle of MEM-stage request/response and sram_control-side signals.
// Ports (by modport):
//   slave  (controller): in  req_valid/req_we/req_size/req_sign/req_addr/req_wdata,
//                            sram_rvalid/sram_rdata
//                        out stall_o, resp_valid/resp_rdata/resp_misalign,
//                            sram_read_ena/sram_we_n/sram_addr/sram_wdata/sram_be_n
//   master (pipeline + sram_control side): the mirror image.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall_o;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_misalign;
  logic              sram_read_ena;
  logic              sram_we_n;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [3:0]        sram_be_n;
  logic              sram_rvalid;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    input  sram_rvalid, sram_rdata,
    output stall_o, resp_valid, resp_rdata, resp_misalign,
    output sram_read_ena, sram_we_n, sram_addr, sram_wdata, sram_be_n
  );

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
    output sram_rvalid, sram_rdata,
    input  stall_o, resp_valid, resp_rdata, resp_misalign,
    input  sram_read_ena, sram_we_n, sram_addr, sram_wdata, sram_be_n
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller feeding sram_control.
// Converts LB/LBU/LH/LHU/LW/SB/SH/SW requests into SRAM reads/writes, steers
// byte lanes (little-endian) and stalls the pipeline until the access completes.
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-high
//   bus  - mem_access_ctrl_if.slave: pipeline request/response + sram_control side
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with resp_misalign instead of performing them.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned WRITE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR, S_DONE} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic              armed_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              read_ena_q;
  logic              we_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_n_q;
  logic              resp_valid_q;
  logic              misalign_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        req_off;
  logic [DATA_W-1:0] wdata_d;
  logic [3:0]        be_n_d;
  logic              misalign_d;
  logic [7:0]        lb;
  logic [15:0]       lh;
  logic [DATA_W-1:0] rdata_d;

  assign req_off = bus.req_addr[1:0];

  // Store steering: replicate the right-aligned datum into every lane it may land in.
  always_comb begin
    wdata_d = bus.req_wdata;
    be_n_d  = 4'b0000;
    case (bus.req_size)
      2'b00: begin
        wdata_d = DATA_W'({4{bus.req_wdata[7:0]}});
        be_n_d  = ~(4'b0001 << req_off);
      end
      2'b01: begin
        wdata_d = DATA_W'({2{bus.req_wdata[15:0]}});
        be_n_d  = req_off[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_d = ((bus.req_size == 2'b01) && req_off[0]) ||
                      (bus.req_size[1] && (req_off != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  // Load extraction from the returned word using the latched offset/size/sign.
  always_comb begin
    case (off_q)
      2'd0:    lb = bus.sram_rdata[7:0];
      2'd1:    lb = bus.sram_rdata[15:8];
      2'd2:    lb = bus.sram_rdata[23:16];
      default: lb = bus.sram_rdata[31:24];
    endcase
    lh = off_q[1] ? bus.sram_rdata[31:16] : bus.sram_rdata[15:0];
    case (size_q)
      2'b00:   rdata_d = sign_q ? {{(DATA_W-8){lb[7]}}, lb}   : {{(DATA_W-8){1'b0}}, lb};
      2'b01:   rdata_d = sign_q ? {{(DATA_W-16){lh[15]}}, lh} : {{(DATA_W-16){1'b0}}, lh};
      default: rdata_d = bus.sram_rdata;
    endcase
  end

  // Access FSM with registered SRAM strobes and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_cnt_q     <= '0;
      armed_q      <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      read_ena_q   <= 1'b0;
      we_n_q       <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_n_q       <= 4'hF;
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      read_ena_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            off_q  <= req_off;
            size_q <= bus.req_size;
            sign_q <= bus.req_sign;
            if (misalign_d) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              misalign_q   <= 1'b1;
              rdata_q      <= '0;
            end else if (bus.req_we) begin
              state_q  <= S_WR;
              wr_cnt_q <= CNT_W'(WRITE_CYCLES - 1);
              we_n_q   <= 1'b0;
              addr_q   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              wdata_q  <= wdata_d;
              be_n_q   <= be_n_d;
            end else begin
              state_q    <= S_RD_ISSUE;
              read_ena_q <= 1'b1;
              addr_q     <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        S_RD_ISSUE: begin
          armed_q <= 1'b0;
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // A valid seen before rvalid has dropped belongs to the previous read.
          if (!bus.sram_rvalid) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            rdata_q      <= rdata_d;
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_WR: begin
          if (wr_cnt_q == '0) begin
            we_n_q       <= 1'b1;
            be_n_q       <= 4'hF;
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            wr_cnt_q <= wr_cnt_q - CNT_W'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.stall_o       = ((state_q == S_IDLE) && bus.req_valid) ||
                             (state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT) ||
                             (state_q == S_WR);
  assign bus.sram_read_ena = read_ena_q;
  assign bus.sram_we_n     = we_n_q;
  assign bus.sram_addr     = addr_q;
  assign bus.sram_wdata    = wdata_q;
  assign bus.sram_be_n     = be_n_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_misalign = misalign_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver pushes expected responses and
// writes into queues; separate monitors pop and compare when the DUT presents them.
module tb_mem_access_ctrl;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned WRITE_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WRITE_CYCLES(WRITE_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        misalign;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be_n;
  } wr_t;

  resp_t       resp_q[$];
  wr_t         wr_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          issue_cyc = 0;
  int          reads = 0;
  int          exp_reads = 0;
  logic [31:0] exp_raddr = 32'h0;
  logic [31:0] next_word = 32'h0;
  int          stale_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor.
  resp_t r;
  initial forever begin
    @(negedge clk);
    if (bus.resp_valid) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        r = resp_q.pop_front();
        if (r.chk_rdata) chk("resp_rdata", bus.resp_rdata, r.rdata);
        chk("resp_misalign", 32'(bus.resp_misalign), 32'(r.misalign));
        chk("resp_latency", 32'(cyc - issue_cyc), 32'(r.lat));
      end
    end
  end

  // Write monitor.
  wr_t w;
  int  wr_len = 0;
  initial forever begin
    @(negedge clk);
    if (bus.sram_we_n == 1'b0) begin
      if (wr_len == 0) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
          w = '{32'h0, 32'h0, 4'h0};
        end else begin
          w = wr_q.pop_front();
        end
      end
      wr_len++;
      chk("wr_addr", bus.sram_addr, w.addr);
      chk("wr_wdata", bus.sram_wdata, w.wdata);
      chk("wr_be_n", 32'(bus.sram_be_n), 32'(w.be_n));
    end else if (wr_len > 0) begin
      chk("wr_len", 32'(wr_len), 32'(WRITE_CYCLES));
      chk("idle_be_n", 32'(bus.sram_be_n), 32'hF);
      wr_len = 0;
    end
  end

  // sram_control read model: rvalid keeps its old value for 'hold' cycles after
  // read_ena, drops for one cycle, then rises with the new word and stays high.
  bit          active = 1'b0;
  int          phase = 0;
  int          pend_hold = 0;
  logic [31:0] pend_word = 32'h0;
  logic        prev_rena = 1'b0;
  logic        nv;
  logic [31:0] nd;
  initial begin
    bus.sram_rvalid = 1'b0;
    bus.sram_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      nv = bus.sram_rvalid;
      nd = bus.sram_rdata;
      if (bus.sram_read_ena) begin
        reads++;
        chk("read_ena_cycle", 32'(cyc - issue_cyc), 32'd1);
        chk("read_addr", bus.sram_addr, exp_raddr);
        if (prev_rena) chk("read_ena_pulse", 32'd1, 32'd0);
        active    = 1'b1;
        phase     = 0;
        pend_word = next_word;
        pend_hold = stale_hold;
      end
      prev_rena = bus.sram_read_ena;
      if (active) begin
        phase++;
        if (phase == pend_hold + 1) begin
          nv = 1'b0;
        end else if (phase >= pend_hold + 2) begin
          nv     = 1'b1;
          nd     = pend_word;
          active = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      bus.sram_rvalid = nv;
      bus.sram_rdata  = nd;
    end
  end

  // Present a request and hold it until stall_o drops; stall must last 'lat' cycles.
  task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wd, input int lat);
    int stall_n;
    stall_n        = 0;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_sign   = sign;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    issue_cyc      = cyc;
    exp_raddr      = {addr[31:2], 2'b00};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.stall_o) break;
      stall_n++;
    end
    chk("stall_cycles", 32'(stall_n), 32'(lat));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] size, input logic sign, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] exp, input int hold,
                         input int lat);
    next_word  = word;
    stale_hold = hold;
    exp_reads++;
    resp_q.push_back('{exp, 1'b1, 1'b0, lat});
    issue(1'b0, size, sign, addr, 32'h0, lat);
  endtask

  task automatic do_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_be_n);
    wr_q.push_back('{{addr[31:2], 2'b00}, exp_wdata, exp_be_n});
    resp_q.push_back('{32'h0, 1'b0, 1'b0, WRITE_CYCLES + 1});
    issue(1'b1, size, 1'b0, addr, wd, WRITE_CYCLES + 1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_sign  = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    #12;
    chk("rst_read_ena", 32'(bus.sram_read_ena), 32'd0);
    chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("rst_be_n", 32'(bus.sram_be_n), 32'hF);
    chk("rst_addr", bus.sram_addr, 32'h0);
    chk("rst_wdata", bus.sram_wdata, 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Loads: size, sign, addr, sram word, expected, stale hold, latency.
    do_load(2'b10, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 4);
    do_load(2'b00, 1'b1, 32'h8000_0013, 32'h8011_2233, 32'hFFFF_FF80, 0, 4);
    do_load(2'b00, 1'b0, 32'h8000_0013, 32'h8011_2233, 32'h0000_0080, 0, 4);
    do_load(2'b01, 1'b1, 32'h8000_0012, 32'h8011_2233, 32'hFFFF_8011, 0, 4);
    do_load(2'b01, 1'b1, 32'h8000_0014, 32'h1234_F00D, 32'hFFFF_F00D, 0, 4);
    do_load(2'b01, 1'b0, 32'h8000_0016, 32'h1234_F00D, 32'h0000_1234, 0, 4);
    do_load(2'b00, 1'b1, 32'h8000_0018, 32'hAAAA_AA7F, 32'h0000_007F, 0, 4);
    do_load(2'b11, 1'b1, 32'h8000_001C, 32'h8765_4321, 32'h8765_4321, 0, 4);

    // Stores: size, addr, right-aligned data, expected lane data, expected be_n.
    do_store(2'b00, 32'h8000_0021, 32'h1234_565A, 32'h5A5A_5A5A, 4'b1101);
    do_store(2'b01, 32'h8000_0032, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b0011);
    do_store(2'b01, 32'h8000_0030, 32'hFFFF_1234, 32'h1234_1234, 4'b1100);
    do_store(2'b10, 32'h8000_0040, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b0000);

    // Back-to-back loads; the second sees the first's valid still high in RD_WAIT.
    do_load(2'b10, 1'b0, 32'h8000_0044, 32'h1111_1111, 32'h1111_1111, 0, 4);
    do_load(2'b10, 1'b0, 32'h8000_0048, 32'h2222_2222, 32'h2222_2222, 1, 5);

    // Reset while waiting for read data: no response, outputs at reset values.
    next_word     = 32'h5555_5555;
    stale_hold    = 0;
    exp_reads++;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h8000_0060;
    bus.req_valid = 1'b1;
    issue_cyc     = cyc;
    exp_raddr     = 32'h8000_0060;
    repeat (2) @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("mid_rst_read_ena", 32'(bus.sram_read_ena), 32'd0);
    chk("mid_rst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("mid_rst_be_n", 32'(bus.sram_be_n), 32'hF);
    chk("mid_rst_addr", bus.sram_addr, 32'h0);
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("mid_rst_stall", 32'(bus.stall_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_load(2'b10, 1'b0, 32'h8000_0064, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 4);

    // Misaligned word load.
`ifdef MEM_ALIGN_CHECK_EN
    begin
      int reads_before;
      reads_before = reads;
      resp_q.push_back('{32'h0, 1'b1, 1'b1, 1});
      issue(1'b0, 2'b10, 1'b1, 32'h8000_0052, 32'h0, 1);
      repeat (3) @(posedge clk);
      chk("misalign_no_read", 32'(reads), 32'(reads_before));
    end
`else
    do_load(2'b10, 1'b0, 32'h8000_0052, 32'h600D_CAFE, 32'h600D_CAFE, 0, 4);
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    chk("read_count", 32'(reads), 32'(exp_reads));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
